// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master: cmd+byte frames with optional read-back byte.
// Define SPI_MASTER_FRAMECNT_EN to add the frame_cnt completed-frame counter.
module spi_master #(
  parameter int RD_WAIT  = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS_n
`ifdef SPI_MASTER_FRAMECNT_EN
  , output logic [15:0] frame_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SELECT, SHIFT_OUT, WAIT, SHIFT_IN, FINISH, GAP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  state_t     state, state_d;
  logic [9:0] frame, frame_d;
  logic [3:0] cnt, cnt_d;
  logic [6:0] rx_shift;
  logic       mosi_d;
  logic       is_read;

  assign is_read = (frame[9:8] == 2'b11);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    frame_d = frame;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SELECT;
          frame_d = {cmd, wr_data};
          cnt_d   = '0;
        end
      end
      SELECT: begin
        state_d = SHIFT_OUT;
        cnt_d   = '0;
      end
      SHIFT_OUT: begin
        if (cnt == 4'd9) begin
          state_d = is_read ? WAIT : FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_d = SHIFT_IN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      SHIFT_IN: begin
        if (cnt == 4'd7) begin
          state_d = FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      FINISH: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        // The last GAP cycle doubles as the accept slot, so a held start
        // yields exactly FINISH + IDLE_GAP high cycles between frames.
        if (cnt == GAP_LAST) begin
          cnt_d = '0;
          if (start) begin
            state_d = SELECT;
            frame_d = {cmd, wr_data};
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    mosi_d = 1'b0;
    if (state_d == SELECT) begin
      mosi_d = frame_d[9];
    end else if (state_d == SHIFT_OUT) begin
      mosi_d = frame_d[4'd9 - cnt_d];
    end
  end

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      frame    <= '0;
      rx_shift <= '0;
      MOSI     <= 1'b0;
      SS_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      frame    <= frame_d;
      MOSI     <= mosi_d;
      SS_n     <= !(state_d inside {SELECT, SHIFT_OUT, WAIT, SHIFT_IN});
      busy     <= (state_d != IDLE);
      done     <= (state_d == FINISH);
      rd_valid <= (state_d == FINISH) && is_read;
      if (state == SHIFT_IN) begin
        rx_shift <= {rx_shift[5:0], MISO};
        if (cnt == 4'd7) begin
          rd_data <= {rx_shift, MISO};
        end
      end
    end
  end

`ifdef SPI_MASTER_FRAMECNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (state_d == FINISH) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a behavioural SPI RAM slave.
// Honours SPI_MASTER_FRAMECNT_EN when defined.
module tb_spi_master;
  localparam int RD_WAIT  = 2;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       MISO = 1'b0;
  logic       busy, done, rd_valid, MOSI, SS_n;
  logic [7:0] rd_data;
`ifdef SPI_MASTER_FRAMECNT_EN
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wr_data(wr_data),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
`ifdef SPI_MASTER_FRAMECNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         acc;
    bit         chk_lat;
    int         exp_gap;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: the RAM as seen through a sequence of completed frames.
  logic [7:0] ref_ram [256];
  logic [7:0] ref_addr = 8'd0;
  logic [7:0] ref_rd = 8'd0;

  // Behavioural slave: decodes MOSI and answers read-data frames on MISO.
  logic [7:0] sl_ram [256];
  logic [7:0] sl_addr = 8'd0;
  logic [9:0] sl_rx = 10'd0;
  logic [7:0] sl_tx = 8'd0;
  int         k = 0;

  always @(negedge clk) begin
    if (!rst_n || SS_n) begin
      k = 0;
      MISO = 1'($urandom);
    end else begin
      k++;
      if (k >= 2 && k <= 11) sl_rx = {sl_rx[8:0], MOSI};
      if (k == 11) begin
        case (sl_rx[9:8])
          2'd0: sl_addr = sl_rx[7:0];
          2'd1: sl_ram[sl_addr] = sl_rx[7:0];
          2'd2: sl_addr = sl_rx[7:0];
          default: sl_tx = sl_ram[sl_addr];
        endcase
      end
      if (k >= 12 + RD_WAIT && k <= 19 + RD_WAIT) MISO = sl_tx[19 + RD_WAIT - k];
      else MISO = 1'($urandom);
    end
  end

  task automatic push_frame(input logic [1:0] c, input logic [7:0] d, input bit chk_lat, input int gap);
    exp_t e;
    case (c)
      2'd0: ref_addr = d;
      2'd1: ref_ram[ref_addr] = d;
      2'd2: ref_addr = d;
      default: ref_rd = ref_ram[ref_addr];
    endcase
    e.cmd = c; e.data = d; e.exp_rd = ref_rd;
    e.acc = cyc; e.chk_lat = chk_lat; e.exp_gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: collects each SS_n-low window and scores it on the done pulse.
  int   low_cnt = 0, high_cnt = 0, gap_seen = 0, done_cnt = 0;
  bit   in_frame = 0;
  logic mosi_bits[$];

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [10:0] act_bits;
    logic        tail;
    bit          is_rd;
    if (!rst_n) begin
      in_frame = 0;
      mosi_bits.delete();
      high_cnt = 0;
    end else begin
      if (!SS_n) begin
        if (!in_frame) begin
          in_frame = 1; low_cnt = 0; gap_seen = high_cnt; mosi_bits.delete();
        end
        low_cnt++;
        mosi_bits.push_back(MOSI);
      end else if (!done) begin
        high_cnt++;
      end
      if (rd_valid && !done) check("rd_valid_without_done", 32'(rd_valid), 32'(done));
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          is_rd = (e.cmd == 2'b11);
          act_bits = '0;
          for (int i = 0; i < 11; i++)
            if (i < mosi_bits.size()) act_bits = {act_bits[9:0], mosi_bits[i]};
          tail = 1'b0;
          for (int i = 11; i < mosi_bits.size(); i++) tail |= mosi_bits[i];
          check("ss_low_cycles", 32'(low_cnt), is_rd ? 32'(19 + RD_WAIT) : 32'd11);
          check("mosi_frame", 32'(act_bits), 32'({e.cmd[1], e.cmd, e.data}));
          if (is_rd) check("mosi_zero_after_cmd", 32'(tail), 32'd0);
          check("rd_valid", 32'(rd_valid), 32'(is_rd));
          check("rd_data", 32'(rd_data), 32'(e.exp_rd));
          check("busy_at_done", 32'(busy), 32'd1);
          if (e.chk_lat)
            check("done_latency", 32'(cyc - e.acc), is_rd ? 32'(20 + RD_WAIT) : 32'd12);
          if (e.exp_gap >= 0) check("gap_cycles", 32'(gap_seen), 32'(e.exp_gap));
        end
        high_cnt = 1;
        in_frame = 0;
        low_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input bit junk);
    wait_idle();
    cmd = c; wr_data = d; start = 1'b1;
    push_frame(c, d, 1'b1, -1);
    @(negedge clk);
    start = 1'b0; cmd = 2'($urandom); wr_data = 8'($urandom);
    if (junk) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        start = !SS_n && ($urandom_range(0, 1) == 1);
        cmd = 2'($urandom); wr_data = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] c;
    logic [7:0] d;
    int         dc;
    for (int i = 0; i < 256; i++) begin
      ref_ram[i] = 8'(i) ^ 8'h5C;
      sl_ram[i]  = 8'(i) ^ 8'h5C;
    end
    repeat (3) @(negedge clk);
    check("reset_ss_n", 32'(SS_n), 32'd1);
    check("reset_mosi", 32'(MOSI), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'd0, 8'h10, 1'b0);
    issue(2'd1, 8'h5A, 1'b0);
    issue(2'd2, 8'h10, 1'b0);
    issue(2'd3, 8'h00, 1'b0);
    wait_idle();
    check("chain_rd_data", 32'(rd_data), 32'h5A);
`ifdef SPI_MASTER_FRAMECNT_EN
    check("frame_cnt_chain", 32'(frame_cnt), 32'd4);
`endif

    issue(2'd0, 8'hA5, 1'b0);

    for (int n = 0; n < 40; n++) begin
      c = 2'($urandom);
      d = c[0] ? 8'($urandom) : 8'($urandom_range(0, 7));
      issue(c, d, 1'b1);
    end

    // Held start: frames must run back to back with FINISH + GAP between.
    wait_idle();
    c = 2'($urandom); d = 8'($urandom_range(0, 7));
    cmd = c; wr_data = d; start = 1'b1;
    push_frame(c, d, 1'b1, -1);
    for (int f = 1; f < 4; f++) begin
      for (int i = 0; i < 100 && !done; i++) @(negedge clk);
      if (!done) check("b2b_done_timeout", 32'(done), 32'd1);
      c = (f == 3) ? 2'd3 : 2'($urandom);
      d = 8'($urandom_range(0, 7));
      cmd = c; wr_data = d;
      push_frame(c, d, 1'b0, 1 + IDLE_GAP);
      @(negedge clk);
    end
    for (int i = 0; i < 10 && SS_n; i++) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Abort during SHIFT_OUT bit 5: no frame is expected from this start.
    cmd = 2'd0; wr_data = 8'hC3; start = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_mid_frame_ss_low", 32'(SS_n), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ss_n", 32'(SS_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_valid", 32'(rd_valid), 32'd0);
    check("abort_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    ref_rd = 8'd0;
    repeat (30) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt), 32'(dc));
`ifdef SPI_MASTER_FRAMECNT_EN
    check("frame_cnt_after_reset", 32'(frame_cnt), 32'd0);
`endif

    issue(2'd3, 8'h00, 1'b0);
    wait_idle();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
